fp_serial_host: RTL and testbench
=================================

FP_SERIAL_HOST -- requirements
Module: fp_serial_host

Interface
REQ-001 SHALL have parameter WORD_W, default 32, operand/result width; must be even; lane width is WORD_W/2.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1023, maximum wait cycles in the WAIT_IN and WAIT_OUT states.
REQ-003 SHALL have port clk_in, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_in, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port op_a_in, input, WORD_W, operand A.
REQ-006 SHALL have port op_b_in, input, WORD_W, operand B.
REQ-007 SHALL have port start_in, input, 1, request to begin a transaction.
REQ-008 SHALL have port busy_out, output, 1, high whenever the state is not IDLE.
REQ-009 SHALL have port result_out, output, WORD_W, the received sum.
REQ-010 SHALL have port result_valid_out, output, 1, high when result_out holds a new result.
REQ-011 SHALL have port result_ack_in, input, 1, consumer accepts the result.
REQ-012 SHALL have ports serial1_out..serial4_out, output, 1 each, operand lanes to the adder.
REQ-013 SHALL have port wr_out, output, 1, write strobe to the adder.
REQ-014 SHALL have port setup_serial_out, output, 1, high while lanes carry valid bits.
REQ-015 SHALL have port output_clk_out, output, 1, result shift clock to the adder.
REQ-016 SHALL have ports input_rdy_in, output_rdy_in and serial_in, input, 1 each, the adder's accept flag, result-ready flag and result bit.
REQ-017 SHALL have port error_out, output, 1, sticky timeout flag.

Function
REQ-018 States SHALL be IDLE, SHIFT, WRITE, WAIT_IN, WAIT_OUT, READ, DONE.
REQ-019 In IDLE with start_in=1, the block SHALL capture op_a_in and op_b_in on that edge, clear error_out, and enter SHIFT; start_in SHALL be ignored in every other state.
REQ-020 Lane mapping SHALL be: lane1 = A upper half, lane2 = A lower half, lane3 = B upper half, lane4 = B lower half, each shifted MSB first.
REQ-021 SHIFT SHALL last exactly WORD_W/2 cycles, with one bit per lane per cycle and setup_serial_out=1 for the whole state.
REQ-022 WRITE SHALL last exactly 1 cycle with wr_out=1, setup_serial_out=0 and all lanes at 0.
REQ-023 WAIT_IN SHALL remain until input_rdy_in=1 is sampled, then go to WAIT_OUT.
REQ-024 WAIT_OUT SHALL remain until output_rdy_in=1 is sampled, then go to READ.
REQ-025 READ SHALL produce WORD_W pulses on output_clk_out, each 1 cycle high and then 1 cycle low, for 2*WORD_W cycles in total.
REQ-026 In READ, serial_in SHALL be sampled on the edge that ends each high phase and shifted MSB first into result_out.
REQ-027 Deassertion of output_rdy_in during READ SHALL NOT abort the read.
REQ-028 On leaving READ, result_valid_out SHALL go to 1 and the state SHALL be DONE.
REQ-029 In DONE, result_valid_out and result_out SHALL hold until result_ack_in=1, then the block SHALL return to IDLE with result_valid_out=0 on the next cycle.
REQ-030 result_out SHALL retain its last value after acknowledge.
REQ-031 From a start edge with zero-wait adder flags, the minimum latency to result_valid_out SHALL be WORD_W/2 + 1 + 1 + 1 + 2*WORD_W cycles.

Reset
REQ-032 rst_in=0 SHALL immediately force the state to IDLE and all outputs, captured operands and counters to 0, including in the middle of a transaction.
REQ-033 After reset release, the first start_in SHALL begin a clean transaction with no residual bits.

Configuration
REQ-034 With FP_HOST_TIMEOUT_EN defined, a cycle counter SHALL run in WAIT_IN and WAIT_OUT and reset on each entry.
REQ-035 With FP_HOST_TIMEOUT_EN defined, reaching TIMEOUT_CYC SHALL set error_out=1 and return the block to IDLE without asserting result_valid_out.
REQ-036 Without FP_HOST_TIMEOUT_EN, the wait states SHALL wait indefinitely and error_out SHALL be tied to 0.

Structure
REQ-037 A shared package fp_host_pkg SHALL hold the state enumeration, the default WORD_W and the lane count (4).
REQ-038 A single sub-module fp_host_piso SHALL implement one parallel-in serial-out lane shifter, instantiated four times.

Verification
REQ-039 With A=0x3F800000, B=0x40000000 and a start pulse, the lanes SHALL carry 0x3F80/0x0000/0x4000/0x0000 MSB first over 16 cycles, followed by one wr_out pulse.
REQ-040 With input_rdy_in and output_rdy_in tied high and a model returning 0x40400000, the bench SHALL see result_out=0x40400000 and result_valid_out at exactly cycle 83 after start.
REQ-041 With start_in held high during SHIFT and DONE, the bench SHALL see no restart and unchanged captured operands.
REQ-042 With rst_in=0 at cycle 40 of READ, all outputs SHALL be 0 at once, the state SHALL be IDLE, and a following transaction SHALL complete correctly.
REQ-043 With FP_HOST_TIMEOUT_EN defined, TIMEOUT_CYC=15 and input_rdy_in held at 0, error_out SHALL be 1 after 15 wait cycles, the state SHALL be IDLE, and result_valid_out SHALL remain 0.
REQ-044 With result_ack_in held low for 10 cycles in DONE, result_valid_out SHALL stay high; on ack, the bench SHALL see IDLE and busy_out=0 on the next cycle.

Source files
------------

// File: rtl/fp_host_pkg.sv
// fp_host_pkg: shared state encoding and sizing for the
// bit-serial floating-point adder host.
package fp_host_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int LANES      = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_WRITE,
    S_WAIT_IN,
    S_WAIT_OUT,
    S_READ,
    S_DONE
  } state_t;

endpackage

// File: rtl/fp_serial_host_if.sv
// fp_serial_host_if: serial bus between the host and the
// bit-serial adder (four operand lanes, strobes, result line).
interface fp_serial_host_if;

  logic serial1_out;
  logic serial2_out;
  logic serial3_out;
  logic serial4_out;
  logic wr_out;
  logic setup_serial_out;
  logic output_clk_out;
  logic input_rdy_in;
  logic output_rdy_in;
  logic serial_in;

  modport master (
    output serial1_out,
    output serial2_out,
    output serial3_out,
    output serial4_out,
    output wr_out,
    output setup_serial_out,
    output output_clk_out,
    input  input_rdy_in,
    input  output_rdy_in,
    input  serial_in
  );

  modport slave (
    input  serial1_out,
    input  serial2_out,
    input  serial3_out,
    input  serial4_out,
    input  wr_out,
    input  setup_serial_out,
    input  output_clk_out,
    output input_rdy_in,
    output output_rdy_in,
    output serial_in
  );

endinterface

// File: rtl/fp_host_piso.sv
// fp_host_piso: one parallel-in serial-out operand lane,
// shifted MSB first, zero-filled behind the data.
module fp_host_piso #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         dout
);

  logic [W-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[W-2:0], 1'b0};
    end
  end

  assign dout = sr[W-1];

endmodule

// File: rtl/fp_serial_host.sv
// fp_serial_host: feeds operands to a 4-lane serial adder and reads
// the sum back. FP_HOST_TIMEOUT_EN bounds the wait states.
module fp_serial_host
  import fp_host_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [WORD_W-1:0] op_a_in,
  input  logic [WORD_W-1:0] op_b_in,
  input  logic              start_in,
  output logic              busy_out,
  output logic [WORD_W-1:0] result_out,
  output logic              result_valid_out,
  input  logic              result_ack_in,
  output logic              error_out,
  fp_serial_host_if.master  bus
);

  localparam int HALF  = WORD_W / 2;
  localparam int CNT_W = $clog2(2 * WORD_W);

  state_t state, state_nx;

  logic [CNT_W-1:0]           cnt;
  logic [WORD_W-1:0]          res;
  logic                       load;
  logic                       shift;
  logic                       tmo_hit;
  logic                       wr;
  logic                       setup;
  logic                       oclk;
  logic                       valid;
  logic                       busy;
  logic [LANES-1:0]           lane_q;
  logic [LANES-1:0][HALF-1:0] lane_din;

  assign load     = (state == S_IDLE) && start_in;
  assign shift    = (state == S_SHIFT);
  assign lane_din = {op_a_in, op_b_in};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_host_piso #(.W(HALF)) u_piso (
      .clk   (clk_in),
      .rst_n (rst_in),
      .load  (load),
      .shift (shift),
      .din   (lane_din[i]),
      .dout  (lane_q[i])
    );
  end

  assign bus.serial1_out = lane_q[3] & shift;
  assign bus.serial2_out = lane_q[2] & shift;
  assign bus.serial3_out = lane_q[1] & shift;
  assign bus.serial4_out = lane_q[0] & shift;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    wr       = 1'b0;
    setup    = 1'b0;
    oclk     = 1'b0;
    valid    = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_in) state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        setup = 1'b1;
        if (cnt == CNT_W'(HALF - 1)) state_nx = S_WRITE;
      end
      S_WRITE: begin
        wr       = 1'b1;
        state_nx = S_WAIT_IN;
      end
      S_WAIT_IN: begin
        if (bus.input_rdy_in) state_nx = S_WAIT_OUT;
        else if (tmo_hit)     state_nx = S_IDLE;
      end
      S_WAIT_OUT: begin
        if (bus.output_rdy_in) state_nx = S_READ;
        else if (tmo_hit)      state_nx = S_IDLE;
      end
      S_READ: begin
        // even cycles are the high phase of each result clock
        oclk = ~cnt[0];
        if (cnt == CNT_W'(2 * WORD_W - 1)) state_nx = S_DONE;
      end
      S_DONE: begin
        valid = 1'b1;
        if (result_ack_in) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt <= '0;
      res <= '0;
    end else begin
      if ((state_nx == state) && (shift || state == S_READ)) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
      if ((state == S_READ) && !cnt[0]) begin
        res <= {res[WORD_W-2:0], bus.serial_in};
      end
    end
  end

`ifdef FP_HOST_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo;
  logic             waiting;
  logic             err;

  assign waiting = (state == S_WAIT_IN) || (state == S_WAIT_OUT);
  assign tmo_hit = (tmo == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tmo <= '0;
      err <= 1'b0;
    end else begin
      tmo <= (waiting && state_nx == state) ? tmo + TMO_W'(1) : '0;
      if (load) begin
        err <= 1'b0;
      end else if (waiting && state_nx == S_IDLE) begin
        err <= 1'b1;
      end
    end
  end

  assign error_out = err;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_hit    = 1'b0;
  assign error_out  = 1'b0;
`endif

  assign busy_out             = busy;
  assign result_valid_out     = valid;
  assign result_out           = res;
  assign bus.wr_out           = wr;
  assign bus.setup_serial_out = setup;
  assign bus.output_clk_out   = oclk;

endmodule

// File: tb/tb_fp_serial_host.sv
// tb_fp_serial_host: randomized bench with a timeline model of
// each transaction and a per-cycle compare process.
module tb_fp_serial_host;

  localparam int W   = 32;
  localparam int H   = W / 2;
  localparam int TMO = 15;
`ifdef FP_HOST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         start = 1'b0;
  logic         busy;
  logic [W-1:0] result;
  logic         valid;
  logic         ack = 1'b0;
  logic         err;

  fp_serial_host_if bus ();

  fp_serial_host #(
    .WORD_W      (W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst_n),
    .op_a_in          (op_a),
    .op_b_in          (op_b),
    .start_in         (start),
    .busy_out         (busy),
    .result_out       (result),
    .result_valid_out (valid),
    .result_ack_in    (ack),
    .error_out        (err),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [9:0]   exp_outs = '0;
  logic [W-1:0] exp_res = '0;
  bit           exp_res_chk = 1'b0;
  bit           chk_en = 1'b0;
  bit           model_err = 1'b0;
  int           cur_k = 0;
  bit           seen_valid = 1'b0;
  int           first_valid_k = -1;

  logic [H-1:0] c1, c2, c3, c4;
  logic [H-1:0] w1, w2, w3, w4;
  int           n_setup = 0;
  int           n_wr = 0;

  task automatic check(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t k=%0d)",
               nm, act, expv, $time, cur_k);
    end
  endtask

  function automatic logic [9:0] dut_outs();
    return {busy, bus.setup_serial_out, bus.wr_out,
            bus.output_clk_out, valid, err,
            bus.serial1_out, bus.serial2_out,
            bus.serial3_out, bus.serial4_out};
  endfunction

  // adder side: collect lane bits while setup is high
  always @(negedge clk) begin
    if (bus.setup_serial_out) begin
      c1 = {c1[H-2:0], bus.serial1_out};
      c2 = {c2[H-2:0], bus.serial2_out};
      c3 = {c3[H-2:0], bus.serial3_out};
      c4 = {c4[H-2:0], bus.serial4_out};
      n_setup++;
    end
    if (bus.wr_out) begin
      w1 = c1; w2 = c2; w3 = c3; w4 = c4;
      n_wr++;
    end
  end

  // single compare process against the timeline model
  always @(negedge clk) begin
    if (chk_en) begin
      if (valid && !seen_valid) begin
        seen_valid    = 1'b1;
        first_valid_k = cur_k;
      end
      check("outs", W'(dut_outs()), W'(exp_outs));
      if (exp_res_chk) check("result", result, exp_res);
    end
  end

  // k is the cycle index after the start edge (k=-1: start cycle)
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] resp, input int wi,
                         input int wo, input int dd, input bit hold,
                         input int rst_rd);
    int t_wi0, t_wo0, t_rd0, t_dn0, t_end, rst_k;
    bit to;
    bit e_busy, e_setup, e_wr, e_oclk, e_valid, e_err;
    logic [3:0] e_lane;
    t_wi0 = H + 1;
    t_wo0 = t_wi0 + wi;
    t_rd0 = t_wo0 + wo;
    t_dn0 = t_rd0 + 2 * W;
    to    = 1'b0;
    if (TO_EN && wi > TMO) begin
      to = 1'b1; t_end = t_wi0 + TMO;
    end else if (TO_EN && wo > TMO) begin
      to = 1'b1; t_end = t_wo0 + TMO;
    end else begin
      t_end = t_dn0 + dd;
    end
    rst_k = (rst_rd >= 0) ? t_rd0 + rst_rd : -100;
    for (int k = -1; k <= t_end; k++) begin
      @(posedge clk);
      #1;
      cur_k = k;
      if (k == -1) begin
        seen_valid = 1'b0; first_valid_k = -1;
        n_setup = 0; n_wr = 0;
        c1 = '0; c2 = '0; c3 = '0; c4 = '0;
      end
      start = (k == -1) || (hold && ((k >= 0 && k < H) ||
              (!to && k >= t_dn0 && k < t_end - 1)));
      op_a = (k == -1) ? a : $urandom;
      op_b = (k == -1) ? b : $urandom;
      bus.input_rdy_in  = (k < t_wi0) ? 1'($urandom) : (k >= t_wo0 - 1);
      bus.output_rdy_in = (k < t_wo0 || k >= t_rd0) ? 1'($urandom)
                                                    : (k == t_rd0 - 1);
      if (k >= t_rd0 && k < t_dn0)
        bus.serial_in = resp[W - 1 - (k - t_rd0) / 2];
      else
        bus.serial_in = 1'($urandom);
      ack = (k >= t_dn0 && !to) ? (k == t_end - 1) : 1'($urandom);
      e_busy  = (k >= 0) && (k < t_end);
      e_setup = (k >= 0) && (k < H);
      e_wr    = (k == H);
      e_oclk  = !to && k >= t_rd0 && k < t_dn0 && ((k - t_rd0) % 2 == 0);
      e_valid = !to && k >= t_dn0 && k < t_end;
      e_err   = (k < 0) ? model_err : (to && k >= t_end);
      e_lane  = '0;
      if (e_setup)
        e_lane = {a[W-1-k], a[H-1-k], b[W-1-k], b[H-1-k]};
      exp_outs = {e_busy, e_setup, e_wr, e_oclk, e_valid, e_err, e_lane};
      exp_res_chk = !to && k >= t_dn0;
      exp_res = resp;
      chk_en = 1'b1;
      if (k == rst_k) begin
        chk_en = 1'b0;
        start  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_outs", W'(dut_outs()), '0);
        check("rst_result", result, '0);
        @(posedge clk);
        #1;
        check("rst_hold", W'(dut_outs()), '0);
        #2 rst_n = 1'b1;
        model_err = 1'b0;
        return;
      end
    end
    model_err = to;
  endtask

  initial begin
    logic [W-1:0] ra, rb, rr;
    bus.input_rdy_in  = 1'b0;
    bus.output_rdy_in = 1'b0;
    bus.serial_in     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", W'(dut_outs()), '0);
    check("reset_result", result, '0);
    #2 rst_n = 1'b1;

    run_txn(32'h3F800000, 32'h40000000, 32'h40400000, 1, 1, 3, 1'b0, -1);
    check("lane1", W'(w1), 32'h3F80);
    check("lane2", W'(w2), 32'h0000);
    check("lane3", W'(w3), 32'h4000);
    check("lane4", W'(w4), 32'h0000);
    check("setup_cycles", n_setup, 16);
    check("wr_pulses", n_wr, 1);
    check("latency", first_valid_k, 83);
    check("result_kept", result, 32'h40400000);

    ra = $urandom; rb = $urandom; rr = $urandom;
    run_txn(ra, rb, rr, 2, 3, 11, 1'b1, -1);
    check("hold_lane1", W'(w1), W'(ra[W-1:H]));
    check("hold_lane4", W'(w4), W'(rb[H-1:0]));
    check("hold_wr_pulses", n_wr, 1);

    run_txn($urandom, $urandom, $urandom, 1, 1, 2, 1'b0, 40);
    run_txn(32'h12345678, 32'h9ABCDEF0, 32'hCAFEF00D, 1, 1, 1, 1'b0, -1);
    check("post_rst_lane1", W'(w1), 32'h1234);
    check("post_rst_lane2", W'(w2), 32'h5678);
    check("post_rst_lane3", W'(w3), 32'h9ABC);
    check("post_rst_lane4", W'(w4), 32'hDEF0);
    check("post_rst_result", result, 32'hCAFEF00D);

    run_txn($urandom, $urandom, $urandom, 40, 2, 2, 1'b0, -1);
    check("long_wait_in_err", W'(err), W'(TO_EN));
    run_txn($urandom, $urandom, $urandom, 3, 30, 2, 1'b0, -1);
    check("long_wait_out_err", W'(err), W'(TO_EN));

    for (int i = 0; i < 8; i++) begin
      run_txn($urandom, $urandom, $urandom, $urandom_range(1, 8),
              $urandom_range(1, 8), $urandom_range(1, 5),
              1'($urandom), -1);
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
